riscv_data_mem: RTL and testbench

- Byte-addressable data-memory responder for the riscv core's load/store path. Replaces the core's direct word-indexed array access.
- Accepts one load/store request at a time over a valid/ready request channel. Returns read data or completion over a valid/ready response channel.
- Performs RISC-V byte-lane selection and sign/zero extension for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Also exposes one memory-mapped GPIO output register.

---
 rtl/riscv_data_mem.sv | 148 ++++++++++++++
 tb/tb_riscv_data_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: byte-addressable data memory plus one GPIO output register.
// A load/store request is taken over a valid/ready request channel. The result
// comes back over a valid/ready response channel. Only one request is in flight
// at a time: IDLE -> ACCESS -> RESP -> IDLE.
//
// Handshake rule, the same on both channels: a transfer happens on a rising
// edge where valid and ready are both 1. The producer holds valid and its
// payload steady until that edge. Ready never depends on valid in the same
// cycle.
module riscv_data_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] GPIO_ADDR   = 32'h0000_1000,
  parameter int          GPIO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [GPIO_WIDTH-1:0] gpio
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Word-organised RAM. Reset does not clear it.
  logic [31:0] mem [DEPTH_WORDS];

  logic             in_ram, in_gpio, f3_ok, misaligned, fault, commit;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wd_lanes, gpio_word, src_word, load_val;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // The responder is ready only while it is idle and not held in reset.
  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign commit    = (state == ACCESS) && lat_we && !fault;

  // Decode the latched request into a fault decision, byte enables and load data.
  always_comb begin
    lane    = lat_addr[1:0];
    idx     = lat_addr[IDX_W+1:2];
    in_ram  = (lat_addr[31:2] < 30'(DEPTH_WORDS));
    in_gpio = (lat_addr[31:2] == GPIO_ADDR[31:2]);
    // Legal stores: 0 to 2. Legal loads: 0, 1, 2, 4 and 5.
    if (lat_we) f3_ok = (lat_f3 <= 3'd2);
    else        f3_ok = (lat_f3[1:0] != 2'd3) && !(lat_f3[2] && lat_f3[1]);
    misaligned = ((lat_f3[1:0] == 2'd1) && lat_addr[0]) ||
                 ((lat_f3[1:0] == 2'd2) && (lane != 2'd0));
    fault = !f3_ok || misaligned || !(in_ram || in_gpio);

    gpio_word = '0;
    gpio_word[GPIO_WIDTH-1:0] = gpio;
    src_word = in_ram ? mem[idx] : gpio_word;
    ld_byte  = src_word[{lane, 3'b000} +: 8];
    ld_half  = lat_addr[1] ? src_word[31:16] : src_word[15:0];

    // funct3 bit 2 selects zero extension (LBU/LHU).
    case (lat_f3[1:0])
      2'd0:    load_val = lat_f3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    load_val = lat_f3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = src_word;
    endcase

    // Replicate the store data across the lanes so that the byte enables choose.
    case (lat_f3[1:0])
      2'd0: begin
        be       = 4'b0001 << lane;
        wd_lanes = {4{lat_wdata[7:0]}};
      end
      2'd1: begin
        be       = lat_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{lat_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = lat_wdata;
      end
    endcase
  end

  // Byte-enabled RAM write, committed on the ACCESS edge only.
  always_ff @(posedge clk) begin
    if (commit && in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

  // Control FSM with the registered response and the GPIO register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
      gpio      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_fault <= fault;
          rsp_rdata <= (fault || lat_we) ? 32'd0 : load_val;
          if (commit && in_gpio) begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
              if (be[i/8]) gpio[i] <= wd_lanes[i];
            end
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Testbench for riscv_data_mem. Expected responses go into a queue when a
// request is driven. A monitor pops and compares them at each response handshake.
module tb_riscv_data_mem;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [7:0]  gpio;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {fault, rdata}

  riscv_data_mem dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .gpio(gpio)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each response on the cycle where it is handed over.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rdata", rsp_rdata, e[31:0]);
        check("fault", 32'(rsp_fault), 32'(e[32]));
      end
    end
  end

  // Driver: present one request, wait for the accept, then check the response latency.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_f);
    int n;
    exp_q.push_back({exp_f, exp_d});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lat_accept_edge", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_next_edge", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_f);
    send(we, f3, addr, wdata, exp_d, exp_f);
    wait_done();
  endtask

  initial begin
    logic [31:0] a, d, e;
    logic [1:0]  ln;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

    // Reset state
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_gpio", 32'(gpio), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Word store and load, then sub-word loads
    txn(1, 3'd2, 32'h10, 32'h8765_43A1, 32'h0, 0);
    txn(0, 3'd2, 32'h10, 32'h0, 32'h8765_43A1, 0);
    txn(0, 3'd0, 32'h10, 32'h0, 32'hFFFF_FFA1, 0);
    txn(0, 3'd4, 32'h10, 32'h0, 32'h0000_00A1, 0);
    txn(0, 3'd1, 32'h12, 32'h0, 32'hFFFF_8765, 0);
    txn(0, 3'd5, 32'h12, 32'h0, 32'h0000_8765, 0);

    // Sub-word stores preserve the neighbouring bytes
    txn(1, 3'd0, 32'h11, 32'h55, 32'h0, 0);
    txn(0, 3'd2, 32'h10, 32'h0, 32'h8765_55A1, 0);
    txn(1, 3'd1, 32'h12, 32'h1234, 32'h0, 0);
    txn(0, 3'd2, 32'h10, 32'h0, 32'h1234_55A1, 0);

    // Faults leave RAM unchanged
    txn(0, 3'd2, 32'h13, 32'h0, 32'h0, 1);
    txn(1, 3'd1, 32'h11, 32'hFFFF, 32'h0, 1);
    txn(0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
    txn(0, 3'd6, 32'h10, 32'h0, 32'h0, 1);
    txn(1, 3'd3, 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
    txn(0, 3'd2, 32'h1000_0000, 32'h0, 32'h0, 1);
    txn(0, 3'd2, 32'h10, 32'h0, 32'h1234_55A1, 0);

    // Top of RAM and just past the GPIO word
    txn(1, 3'd1, 32'hFFE, 32'hBEEF, 32'h0, 0);
    txn(1, 3'd0, 32'hFFF, 32'h7E, 32'h0, 0);
    txn(0, 3'd0, 32'hFFF, 32'h0, 32'h0000_007E, 0);
    txn(0, 3'd1, 32'hFFE, 32'h0, 32'h0000_7EEF, 0);
    txn(0, 3'd0, 32'h1004, 32'h0, 32'h0, 1);

    // Random word stores read back as zero-extended bytes
    for (int i = 0; i < 8; i++) begin
      a  = 32'($urandom_range(32'h40, 32'h3F0)) << 2;
      d  = $urandom;
      ln = 2'($urandom_range(0, 3));
      e  = (d >> (8 * ln)) & 32'hFF;
      txn(1, 3'd2, a, d, 32'h0, 0);
      txn(0, 3'd4, a | 32'(ln), 32'h0, e, 0);
    end

    // GPIO register
    txn(1, 3'd2, 32'h1000, 32'hFFFF_FF5A, 32'h0, 0);
    check("gpio_after_sw", 32'(gpio), 32'h5A);
    txn(0, 3'd4, 32'h1000, 32'h0, 32'h0000_005A, 0);
    txn(0, 3'd0, 32'h1000, 32'h0, 32'h0000_005A, 0);
    txn(1, 3'd0, 32'h1001, 32'h33, 32'h0, 0);
    txn(0, 3'd2, 32'h1000, 32'h0, 32'h0000_005A, 0);

    // Response stall, with a second request waiting
    rsp_ready = 1'b0;
    send(0, 3'd2, 32'h10, 32'h0, 32'h1234_55A1, 0);
    exp_q.push_back({1'b0, 32'h0000_00A1});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd4; req_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, 32'h1234_55A1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("second_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_done();

    // Reset while in ACCESS: the store must not commit, and gpio clears at once
    txn(1, 3'd2, 32'h20, 32'h1111_1111, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("gpio_before_rst", 32'(gpio), 32'h5A);
    rst = 1'b1;
    #1;
    check("rst_async_gpio", 32'(gpio), 32'd0);
    check("rst_async_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    txn(0, 3'd2, 32'h20, 32'h0, 32'h1111_1111, 0);

    // Reset while in RESP: the response is dropped, the committed store stays
    rsp_ready = 1'b0;
    send(1, 3'd2, 32'h24, 32'hCAFE_F00D, 32'h0, 0);
    rst = 1'b1;
    #1;
    check("rst_resp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    txn(0, 3'd2, 32'h24, 32'h0, 32'hCAFE_F00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
